// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: memory freeze, branch flush, load-use bubble, fetch bubble.
// Control enables are combinational; mem_timeout and stall_cycles are registered.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IFIDrs1,
    input  logic [4:0]       IFIDrs2,
    input  logic [4:0]       IDEXrd,
    input  logic             IDEXmemread,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             MEMWBstall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic {StRun, StMemWait} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic timeout_hit;
    logic freeze;
    logic load_use;

    always_comb begin
        timeout_hit = (state_q == StMemWait) && !dmem_ready &&
                      (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1));
        freeze      = ((state_q == StRun) && dmem_req && !dmem_ready) ||
                      ((state_q == StMemWait) && !dmem_ready && !timeout_hit);
        load_use    = IDEXmemread && (IDEXrd != 5'd0) &&
                      ((IDEXrd == IFIDrs1) || (IDEXrd == IFIDrs2));
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        MEMWBstall  = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_write  = 1'b0;
            idex_flush  = 1'b1;
            exmem_write = 1'b0;
            MEMWBstall  = 1'b1;
        end else if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            MEMWBstall  = 1'b1;
        end else if (branch_taken) begin
            // The dependent instruction is flushed, so no load-use bubble is needed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = 1'b0;
        stall_cycles_d = stall_cycles_q;
        if (freeze) begin
            state_d    = StMemWait;
            wait_cnt_d = (state_q == StRun) ? WaitW'(1) : wait_cnt_q + WaitW'(1);
        end else begin
            state_d       = StRun;
            wait_cnt_d    = '0;
            mem_timeout_d = timeout_hit;
        end
        if (!pc_write && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 6;
    localparam int          STALL_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       IFIDrs1, IFIDrs2, IDEXrd;
    logic             IDEXmemread, branch_taken, dmem_req, dmem_ready, imem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write;
    logic             MEMWBstall, mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Model: a memory access in progress is tracked by how many cycles it has been frozen.
    int   m_frozen_run = 0;
    bit   m_pulse      = 0;
    int   m_stall      = 0;
    bit   m_freeze, m_tmo;
    logic [6:0] m_ctrl;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       memread, br, req, rdy, irdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    hazard_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2), .IDEXrd(IDEXrd),
        .IDEXmemread(IDEXmemread), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .MEMWBstall(MEMWBstall), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input int s1, input int s2, input int d,
                                input logic mr, input logic b, input logic rq,
                                input logic rd_y, input logic ir, input logic [6:0] e);
        vec_t v;
        v.rst = r; v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.rd = 5'(d);
        v.memread = mr; v.br = b; v.req = rq; v.rdy = rd_y; v.irdy = ir; v.exp = e;
        return v;
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, MEMWBstall}
    function automatic logic [6:0] model_ctrl(input bit r, input bit fr, input bit b,
                                              input bit lu, input bit fe);
        if (r)       return 7'b0010101;
        else if (fr) return 7'b0000001;
        else if (b)  return 7'b1111110;
        else if (lu) return 7'b0001110;
        else if (fe) return 7'b0111010;
        else         return 7'b1101010;
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write,
                MEMWBstall};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; IFIDrs1 = v.rs1; IFIDrs2 = v.rs2; IDEXrd = v.rd;
        IDEXmemread = v.memread; branch_taken = v.br; dmem_req = v.req;
        dmem_ready = v.rdy; imem_ready = v.irdy;
    endtask

    task automatic model_eval();
        bit waiting, lu;
        waiting  = (m_frozen_run > 0);
        m_tmo    = waiting && !dmem_ready && (m_frozen_run == int'(MEM_TIMEOUT) - 1);
        m_freeze = !dmem_ready && (waiting ? !m_tmo : dmem_req);
        lu       = IDEXmemread && (IDEXrd != 0) && (IDEXrd == IFIDrs1 || IDEXrd == IFIDrs2);
        m_ctrl   = model_ctrl(rst, m_freeze, branch_taken, lu, !imem_ready);
    endtask

    task automatic check_model(input string tag);
        model_eval();
        check({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(m_ctrl));
        check({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_pulse));
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
    endtask

    // Advance one clock: model state follows the inputs present at the edge.
    task automatic clock();
        @(posedge clk);
        model_eval();
        if (rst) begin
            m_frozen_run = 0; m_pulse = 0; m_stall = 0;
        end else begin
            m_pulse      = m_tmo;
            m_frozen_run = m_freeze ? m_frozen_run + 1 : 0;
            if (!m_ctrl[6] && m_stall < STALL_MAX) m_stall++;
        end
        @(negedge clk);
    endtask

    task automatic mem_cycle(input logic r, input logic rq, input logic rd_y);
        apply(mk(r, 1, 2, 3, 1'b0, 1'b0, rq, rd_y, 1'b1, 7'd0));
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 2, 3, 0, 0, 0, 1, 1, 7'b0010101);  // reset
        vecs[1]  = mk(0, 1, 2, 3, 1, 0, 0, 1, 1, 7'b1101010);  // no hazard
        vecs[2]  = mk(0, 5, 7, 5, 1, 0, 0, 1, 1, 7'b0001110);  // load-use rs1
        vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 7'b1101010);  // x0 never hazards
        vecs[4]  = mk(0, 9, 5, 5, 1, 0, 0, 1, 1, 7'b0001110);  // load-use rs2
        vecs[5]  = mk(0, 5, 5, 5, 0, 0, 0, 1, 1, 7'b1101010);  // not a load
        vecs[6]  = mk(0, 5, 1, 5, 1, 1, 0, 1, 1, 7'b1111110);  // branch masks load-use
        vecs[7]  = mk(0, 1, 2, 3, 0, 0, 0, 1, 0, 7'b0111010);  // fetch miss
        vecs[8]  = mk(0, 5, 1, 5, 1, 0, 0, 1, 0, 7'b0001110);  // load-use beats fetch
        vecs[9]  = mk(0, 1, 2, 3, 0, 1, 0, 1, 0, 7'b1111110);  // branch beats fetch
        vecs[10] = mk(0, 1, 2, 3, 0, 0, 1, 1, 1, 7'b1101010);  // zero-wait access
        vecs[11] = mk(0, 5, 1, 5, 1, 1, 1, 0, 0, 7'b0000001);  // freeze beats all
        vecs[12] = mk(0, 5, 1, 5, 1, 1, 1, 1, 1, 7'b1111110);  // release, held branch fires

        apply(vecs[0]);
        clock();
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d.ctrl", i), 32'(dut_ctrl()), 32'(vecs[i].exp));
            check_model($sformatf("vec%0d", i));
            clock();
        end

        // Three wait cycles, then completion on the fourth.
        for (int i = 0; i < 4; i++) begin
            mem_cycle(1'b0, 1'b1, (i == 3));
            check($sformatf("wait3.memwb%0d", i), 32'(MEMWBstall), (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("wait3.pcw%0d", i), 32'(pc_write), (i < 3) ? 32'd0 : 32'd1);
            clock();
        end

        // Memory never answers: forced release on the fourth cycle, one-cycle pulse after.
        for (int i = 0; i < 4; i++) begin
            mem_cycle(1'b0, 1'b1, 1'b0);
            check($sformatf("tmo.memwb%0d", i), 32'(MEMWBstall), (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("tmo.pulse_lo%0d", i), 32'(mem_timeout), 32'd0);
            clock();
        end
        mem_cycle(1'b0, 1'b0, 1'b0);
        check("tmo.pulse", 32'(mem_timeout), 32'd1);
        check("tmo.run", 32'(MEMWBstall), 32'd0);
        clock();
        mem_cycle(1'b0, 1'b0, 1'b0);
        check("tmo.pulse_end", 32'(mem_timeout), 32'd0);
        clock();

        // Reset lands on the cycle that would otherwise time out.
        for (int i = 0; i < 3; i++) begin
            mem_cycle(1'b0, 1'b1, 1'b0);
            clock();
        end
        mem_cycle(1'b1, 1'b1, 1'b0);
        check("rstwait.ctrl", 32'(dut_ctrl()), 32'h15);
        clock();
        mem_cycle(1'b0, 1'b0, 1'b0);
        check("rstwait.memwb", 32'(MEMWBstall), 32'd0);
        check("rstwait.stall", 32'(stall_cycles), 32'd0);
        check("rstwait.pulse", 32'(mem_timeout), 32'd0);
        clock();
        mem_cycle(1'b0, 1'b0, 1'b0);
        check("rstwait.pulse2", 32'(mem_timeout), 32'd0);
        clock();

        // Counter saturation under a long fetch stall.
        mem_cycle(1'b1, 1'b0, 1'b1);
        clock();
        for (int i = 0; i < STALL_MAX + 6; i++) begin
            apply(mk(0, 1, 2, 3, 0, 0, 0, 1, 0, 7'd0));
            clock();
        end
        #1;
        check("sat.stall", 32'(stall_cycles), 32'(STALL_MAX));
        check_model("sat");

        // Randomized run against the model.
        mem_cycle(1'b1, 1'b0, 1'b1);
        clock();
        for (int i = 0; i < 2000; i++) begin
            vec_t v;
            v = mk(($urandom_range(0, 49) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 7'd0);
            apply(v);
            #1;
            check_model($sformatf("rnd%0d", i));
            clock();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
